mac_pipe: RTL

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_pkg.sv | 12 +
 rtl/mac_sat.sv | 27 ++
 rtl/mac_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared opcodes and default widths for the mac_pipe multiply-accumulate block.
package mac_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int GUARD_W_DEF = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_MAC = 3'b010;
  localparam logic [2:0] OP_SAT = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_MSU = 3'b101;
endpackage

// File: rtl/mac_sat.sv
// Combinational clamp of the accumulator to the signed 2*DATA_W range, with hit detect.
module mac_sat #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8
) (
  input  logic [2*DATA_W+GUARD_W-1:0] acc_i,
  output logic [2*DATA_W+GUARD_W-1:0] acc_o,
  output logic                        hit_o
);
  localparam int PW    = 2*DATA_W;
  localparam int ACC_W = PW + GUARD_W;

  // In range exactly when the guard bits and the result MSB all agree.
  logic [GUARD_W:0] top;
  logic             in_range;

  assign top      = acc_i[ACC_W-1:PW-1];
  assign in_range = (&top) | ~(|top);
  assign hit_o    = ~in_range;

  always_comb begin
    acc_o = acc_i;
    if (!in_range)
      acc_o = acc_i[ACC_W-1] ? {{(GUARD_W+1){1'b1}}, {(PW-1){1'b0}}}
                             : {{(GUARD_W+1){1'b0}}, {(PW-1){1'b1}}};
  end
endmodule

// File: rtl/mac_pipe.sv
// Two-stage signed multiply-accumulate pipeline with valid/ready handshakes.
// SAT opcode is compiled in only when MAC_PIPE_SAT_EN is defined.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            instruction,
  input  logic [DATA_W-1:0]     multiplier,
  input  logic [DATA_W-1:0]     multiplicand,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   result,
  output logic [GUARD_W-1:0]    protect,
  output logic                  sat_hit
);
  localparam int PW    = 2*DATA_W;
  localparam int ACC_W = PW + GUARD_W;

  logic                    s1_valid_q;
  logic [2:0]              s1_op_q;
  logic [ACC_W-1:0]        s1_prod_q;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    out_valid_q;
  logic signed [PW-1:0]    prod;
  logic                    adv;
  logic                    accept;

  assign prod     = $signed(multiplier) * $signed(multiplicand);
  assign adv      = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !reset && (!s1_valid_q || adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_NOP;
      s1_prod_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q   <= instruction;
        s1_prod_q <= {{GUARD_W{prod[PW-1]}}, prod};
      end
    end
  end

`ifdef MAC_PIPE_SAT_EN
  logic [ACC_W-1:0] sat_acc;
  logic             sat_chg;
  logic             sat_hit_d, sat_hit_q;

  mac_sat #(.DATA_W(DATA_W), .GUARD_W(GUARD_W)) u_sat (
    .acc_i (acc_q),
    .acc_o (sat_acc),
    .hit_o (sat_chg)
  );
`endif

  always_comb begin
    acc_d = acc_q;
`ifdef MAC_PIPE_SAT_EN
    sat_hit_d = 1'b0;
`endif
    case (s1_op_q)
      OP_MUL: acc_d = s1_prod_q;
      OP_MAC: acc_d = acc_q + s1_prod_q;
      OP_MSU: acc_d = acc_q - s1_prod_q;
      OP_CLR: acc_d = '0;
`ifdef MAC_PIPE_SAT_EN
      OP_SAT: begin
        acc_d     = sat_acc;
        sat_hit_d = sat_chg;
      end
`endif
      default: acc_d = acc_q;
    endcase
  end

  // The accumulator doubles as the output register, so a stalled beat holds by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      acc_q       <= acc_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MAC_PIPE_SAT_EN
  always_ff @(posedge clk) begin
    if (reset)    sat_hit_q <= 1'b0;
    else if (adv) sat_hit_q <= sat_hit_d;
  end
  assign sat_hit = sat_hit_q;
`else
  assign sat_hit = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign result    = acc_q[PW-1:0];
  assign protect   = acc_q[ACC_W-1:PW];
endmodule
